// File: rtl/multicam_scanout_ctrl_if.sv
// Pixel-side bus of the multi-camera scanout controller: VGA decoder inputs,
// frame-buffer read port, freeze controls and the 4-bit colour outputs.
interface multicam_scanout_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 17
);
    logic                   DE;
    logic [9:0]             x_pixel;
    logic [9:0]             y_pixel;
    logic                   mode;
    logic [1:0]             ch_sel;
    logic [NUM_CH-1:0]      freeze_req;
    logic [NUM_CH*16-1:0]   rData;
    logic [ADDR_W-1:0]      rAddr;
    logic [NUM_CH-1:0]      den;
    logic [NUM_CH-1:0]      freeze;
    logic [NUM_CH-1:0]      freeze_done;
    logic [NUM_CH-1:0]      freeze_state;
    logic                   frame_tick;
    logic [3:0]             r_port;
    logic [3:0]             g_port;
    logic [3:0]             b_port;

    modport master (
        output DE, x_pixel, y_pixel, mode, ch_sel, freeze_req, rData,
        input  rAddr, den, freeze, freeze_done, freeze_state, frame_tick,
               r_port, g_port, b_port
    );

    modport slave (
        input  DE, x_pixel, y_pixel, mode, ch_sel, freeze_req, rData,
        output rAddr, den, freeze, freeze_done, freeze_state, frame_tick,
               r_port, g_port, b_port
    );
endinterface

// File: rtl/multicam_scanout_ctrl.sv
// Scanout controller: SINGLE (2x upscale) or QUAD (2x2 tiled) read addressing for
// up to four QVGA frame buffers, RGB565 to 4-bit VGA, and per-camera freeze timers.
module multicam_scanout_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int IMG_W         = 320,
    parameter int IMG_H         = 240,
    parameter int ADDR_W        = 17,
    parameter int FREEZE_FRAMES = 120
) (
    input  logic                   clk,
    input  logic                   reset,
    multicam_scanout_ctrl_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, FROZEN = 1'b1} frz_state_e;

    localparam logic [ADDR_W-1:0] W_A  = ADDR_W'(IMG_W);
    localparam logic [9:0]        W_X  = 10'(IMG_W);
    localparam logic [9:0]        H_Y  = 10'(IMG_H);
    localparam logic [9:0]        W2_X = 10'(2 * IMG_W);
    localparam logic [9:0]        H2_Y = 10'(2 * IMG_H);
    localparam logic [9:0]        FRZ  = 10'(FREEZE_FRAMES);

    logic                frame_tick_q, prev_zero_q, zero_now;
    logic                mode_q;
    logic [1:0]          ch_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_CH-1:0]   den_q, den_d;
    logic [1:0]          ch1_q, ch2_q, ch_d;
    logic                vld1_q, vld2_q, valid_d;
    logic                tile_x, tile_y;
    logic [9:0]          xs, ys;
    logic [15:0]         word;
    logic [3:0]          r_q, g_q, b_q;

    frz_state_e          st_q  [NUM_CH];
    frz_state_e          st_d  [NUM_CH];
    logic [9:0]          cnt_q [NUM_CH];
    logic [9:0]          cnt_d [NUM_CH];
    logic [NUM_CH-1:0]   done_q, done_d, frozen_w;

    assign zero_now = (bus.x_pixel == 10'd0) && (bus.y_pixel == 10'd0);

    // Stage 1 address generation; QUAD folds coordinates by subtraction.
    always_comb begin
        tile_x = bus.x_pixel >= W_X;
        tile_y = bus.y_pixel >= H_Y;
        if (mode_q) begin
            ch_d = {tile_y, tile_x};
            xs   = tile_x ? bus.x_pixel - W_X : bus.x_pixel;
            ys   = tile_y ? bus.y_pixel - H_Y : bus.y_pixel;
        end else begin
            ch_d = ch_q;
            xs   = {1'b0, bus.x_pixel[9:1]};
            ys   = {1'b0, bus.y_pixel[9:1]};
        end
        addr_d  = ADDR_W'(ys) * W_A + ADDR_W'(xs);
        valid_d = bus.DE && (bus.x_pixel < W2_X) && (bus.y_pixel < H2_Y)
                  && ({1'b0, ch_d} < 3'(NUM_CH));
        den_d   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            den_d[c] = valid_d && (ch_d == 2'(c));
        end
    end

    always_comb begin
        word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch2_q == 2'(c)) word = bus.rData[16*c +: 16];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
            prev_zero_q  <= 1'b0;
            mode_q       <= 1'b0;
            ch_q         <= '0;
            addr_q       <= '0;
            den_q        <= '0;
            ch1_q        <= '0;
            ch2_q        <= '0;
            vld1_q       <= 1'b0;
            vld2_q       <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
        end else begin
            frame_tick_q <= zero_now && !prev_zero_q;
            prev_zero_q  <= zero_now;
            if (frame_tick_q) begin
                mode_q <= bus.mode;
                ch_q   <= bus.ch_sel;
            end
            addr_q <= addr_d;
            den_q  <= den_d;
            ch1_q  <= ch_d;
            vld1_q <= valid_d;
            ch2_q  <= ch1_q;
            vld2_q <= vld1_q;
            r_q    <= vld2_q ? word[15:12] : 4'd0;
            g_q    <= vld2_q ? word[10:7]  : 4'd0;
            b_q    <= vld2_q ? word[4:1]   : 4'd0;
        end
    end

    // A request arriving with frame_tick loads the counter and skips that decrement.
    always_comb begin
        done_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            st_d[c]  = st_q[c];
            cnt_d[c] = cnt_q[c];
            case (st_q[c])
                IDLE: begin
                    if (bus.freeze_req[c]) begin
                        st_d[c]  = FROZEN;
                        cnt_d[c] = FRZ;
                    end
                end
                FROZEN: begin
                    if (frame_tick_q) begin
                        if (cnt_q[c] == 10'd1) begin
                            st_d[c]   = IDLE;
                            cnt_d[c]  = '0;
                            done_d[c] = 1'b1;
                        end else begin
                            cnt_d[c] = cnt_q[c] - 10'd1;
                        end
                    end
                end
                default: st_d[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]  <= IDLE;
                cnt_q[c] <= '0;
            end
            done_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]  <= st_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            done_q <= done_d;
        end
    end

    always_comb begin
        frozen_w = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            frozen_w[c] = (st_q[c] == FROZEN);
        end
    end

    assign bus.rAddr        = addr_q;
    assign bus.den          = den_q;
    assign bus.freeze       = frozen_w;
    assign bus.freeze_state = frozen_w;
    assign bus.freeze_done  = done_q;
    assign bus.frame_tick   = frame_tick_q;
    assign bus.r_port       = r_q;
    assign bus.g_port       = g_q;
    assign bus.b_port       = b_q;
endmodule

// File: tb/tb_multicam_scanout_ctrl.sv
// Bench for multicam_scanout_ctrl: a 4-channel and a 2-channel instance share the
// same coordinate stream; expected address/enable/colour are queued per driven cycle.
module tb_multicam_scanout_ctrl;
  logic clk = 1'b0;
  logic rst_g;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  multicam_scanout_ctrl_if #(.NUM_CH(4), .ADDR_W(17)) bus_a ();
  multicam_scanout_ctrl_if #(.NUM_CH(2), .ADDR_W(17)) bus_b ();

  multicam_scanout_ctrl #(.NUM_CH(4), .FREEZE_FRAMES(3)) dut_a (
    .clk(clk), .reset(rst_g), .bus(bus_a.slave));
  multicam_scanout_ctrl #(.NUM_CH(2), .FREEZE_FRAMES(3)) dut_b (
    .clk(clk), .reset(rst_g), .bus(bus_b.slave));

  typedef struct packed {
    logic [16:0] addr;
    logic [3:0]  den_a;
    logic [1:0]  den_b;
  } s1_t;

  typedef struct packed {
    logic [11:0] col_a;
    logic [11:0] col_b;
  } s3_t;

  s1_t exp_q[$];
  s3_t exp_col_q[$];

  logic       mode_g, mode_m, tick_m, prev_m;
  logic [1:0] ch_g, ch_m;
  logic       de_g;

  function automatic logic [15:0] pix(input int c, input logic [16:0] a);
    logic [15:0] k;
    if (c == 1 && a == 17'd8050) return 16'hF800;
    k = 16'(c * 11133 + 4369);
    return a[15:0] ^ k ^ {a[16], 15'd0};
  endfunction

  function automatic logic [11:0] rgb(input logic [15:0] w);
    return {w[15:12], w[10:7], w[4:1]};
  endfunction

  // Frame-buffer model: synchronous read, latency 1.
  logic [63:0] rdata_a;
  logic [31:0] rdata_b;
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) rdata_a[16*c +: 16] <= pix(c, bus_a.rAddr);
    for (int c = 0; c < 2; c++) rdata_b[16*c +: 16] <= pix(c, bus_b.rAddr);
  end
  assign bus_a.rData = rdata_a;
  assign bus_b.rData = rdata_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int x, input int y, input logic de, input logic [3:0] req);
    s1_t        e1;
    s3_t        e3;
    logic [1:0] ch;
    int         ax, ay;
    logic       vis, va, vb;
    logic       zero;
    @(negedge clk);
    bus_a.x_pixel = 10'(x);  bus_b.x_pixel = 10'(x);
    bus_a.y_pixel = 10'(y);  bus_b.y_pixel = 10'(y);
    bus_a.DE = de;           bus_b.DE = de;
    bus_a.mode = mode_g;     bus_b.mode = mode_g;
    bus_a.ch_sel = ch_g;     bus_b.ch_sel = ch_g;
    bus_a.freeze_req = req;  bus_b.freeze_req = req[1:0];
    if (mode_m) begin
      ch = {(y >= 240), (x >= 320)};
      ax = (x >= 320) ? x - 320 : x;
      ay = (y >= 240) ? y - 240 : y;
    end else begin
      ch = ch_m;
      ax = x / 2;
      ay = y / 2;
    end
    e1.addr  = 17'(ay * 320 + ax);
    vis      = de && (x < 640) && (y < 480) && !rst_g;
    va       = vis && (int'(ch) < 4);
    vb       = vis && (int'(ch) < 2);
    e1.den_a = va ? 4'(1 << ch) : 4'd0;
    e1.den_b = vb ? 2'(1 << ch) : 2'd0;
    e3.col_a = va ? rgb(pix(int'(ch), e1.addr)) : 12'd0;
    e3.col_b = vb ? rgb(pix(int'(ch), e1.addr)) : 12'd0;
    exp_q.push_back(e1);
    exp_col_q.push_back(e3);
    zero = (x == 0) && (y == 0);
    if (rst_g) begin
      mode_m = 1'b0; ch_m = 2'd0; tick_m = 1'b0; prev_m = 1'b0;
    end else begin
      if (tick_m) begin
        mode_m = mode_g;
        ch_m   = ch_g;
      end
      tick_m = zero && !prev_m;
      prev_m = zero;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Jump to frame start; req is driven in the cycle where frame_tick is high.
  task automatic frame(input logic [3:0] req);
    step(7, 7, de_g, 4'd0);
    step(0, 0, de_g, 4'd0);
    after_edge();
    chk("tick_hi", 32'(bus_a.frame_tick), 32'd1);
    step(1, 0, de_g, req);
    after_edge();
    chk("tick_lo", 32'(bus_b.frame_tick), 32'd0);
  endtask

  always @(posedge clk) begin
    s1_t e1;
    s3_t e3;
    #1;
    if (exp_q.size() > 0) begin
      e1 = exp_q.pop_front();
      chk("den_a", 32'(bus_a.den), 32'(e1.den_a));
      chk("den_b", 32'(bus_b.den), 32'(e1.den_b));
      if (e1.den_a != 4'd0) chk("addr_a", 32'(bus_a.rAddr), 32'(e1.addr));
      if (e1.den_b != 2'd0) chk("addr_b", 32'(bus_b.rAddr), 32'(e1.addr));
    end
    if (exp_col_q.size() >= 3) begin
      e3 = exp_col_q.pop_front();
      chk("col_a", 32'({bus_a.r_port, bus_a.g_port, bus_a.b_port}), 32'(e3.col_a));
      chk("col_b", 32'({bus_b.r_port, bus_b.g_port, bus_b.b_port}), 32'(e3.col_b));
    end
  end

  initial begin
    rst_g = 1'b1; mode_g = 1'b0; ch_g = 2'd0; de_g = 1'b0;
    mode_m = 1'b0; ch_m = 2'd0; tick_m = 1'b0; prev_m = 1'b0;
    repeat (4) step(5, 5, 1'b0, 4'd0);
    after_edge();
    chk("rst_freeze", 32'(bus_a.freeze), 32'd0);
    chk("rst_done", 32'(bus_a.freeze_done), 32'd0);
    chk("rst_tick", 32'(bus_a.frame_tick), 32'd0);
    chk("rst_col", 32'({bus_a.r_port, bus_a.g_port, bus_a.b_port}), 32'd0);
    rst_g = 1'b0;
    step(5, 5, 1'b0, 4'd0);

    // SINGLE, channel 1
    de_g = 1'b1; ch_g = 2'd1;
    frame(4'd0);
    step(101, 51, 1'b1, 4'd0);
    after_edge();
    chk("single_addr", 32'(bus_a.rAddr), 32'd8050);
    chk("single_den", 32'(bus_a.den), 32'h2);
    step(9, 9, 1'b1, 4'd0);
    step(9, 9, 1'b1, 4'd0);
    after_edge();
    chk("single_red", 32'({bus_a.r_port, bus_a.g_port, bus_a.b_port}), 32'hF00);
    repeat (20) step($urandom_range(0, 639), $urandom_range(1, 479), 1'b1, 4'd0);

    // QUAD
    mode_g = 1'b1;
    frame(4'd0);
    step(639, 479, 1'b1, 4'd0);
    after_edge();
    chk("quad_max_addr", 32'(bus_a.rAddr), 32'd76799);
    chk("quad_max_den", 32'(bus_a.den), 32'h8);
    step(400, 300, 1'b1, 4'd0);
    step(320, 240, 1'b1, 4'd0);
    step(319, 239, 1'b1, 4'd0);
    step(320, 0, 1'b1, 4'd0);
    step(0, 240, 1'b1, 4'd0);
    repeat (20) step($urandom_range(0, 639), $urandom_range(1, 479), 1'b1, 4'd0);

    // Mode flips mid-frame; addressing follows only after the next frame start
    step(10, 100, 1'b1, 4'd0);
    mode_g = 1'b0;
    step(500, 100, 1'b1, 4'd0);
    step(600, 101, 1'b1, 4'd0);
    after_edge();
    chk("midframe_quad_den", 32'(bus_a.den), 32'h2);
    frame(4'd0);
    step(600, 101, 1'b1, 4'd0);
    after_edge();
    chk("newframe_single_den", 32'(bus_a.den), 32'h2);
    chk("newframe_single_addr", 32'(bus_a.rAddr), 32'(50 * 320 + 300));
    repeat (10) step($urandom_range(0, 639), $urandom_range(1, 479), 1'b1, 4'd0);

    // Blanking and out-of-range coordinates
    repeat (3) step($urandom_range(0, 639), $urandom_range(1, 479), 1'b0, 4'd0);
    step(700, 100, 1'b1, 4'd0);
    step(100, 500, 1'b1, 4'd0);
    step(640, 479, 1'b1, 4'd0);

    // Channel 3: valid on the 4-channel build, black on the 2-channel build
    ch_g = 2'd3;
    frame(4'd0);
    repeat (10) step($urandom_range(0, 639), $urandom_range(1, 479), 1'b1, 4'd0);

    // Freeze channel 2; a repeated request must not extend it
    de_g = 1'b0;
    repeat (3) step(5, 5, 1'b0, 4'd0);
    step(7, 7, 1'b0, 4'b0100);
    after_edge();
    chk("frz2_on", 32'(bus_a.freeze), 32'h4);
    frame(4'd0);
    chk("frz2_t1", 32'(bus_a.freeze), 32'h4);
    chk("frz2_t1_done", 32'(bus_a.freeze_done), 32'h0);
    frame(4'b0100);
    chk("frz2_t2", 32'(bus_a.freeze), 32'h4);
    frame(4'd0);
    chk("frz2_off", 32'(bus_a.freeze), 32'h0);
    chk("frz2_done", 32'(bus_a.freeze_done), 32'h4);
    step(5, 5, 1'b0, 4'd0);
    after_edge();
    chk("frz2_done_pulse", 32'(bus_a.freeze_done), 32'h0);
    chk("frz2_b_untouched", 32'(bus_b.freeze), 32'h0);

    // Request coincident with frame_tick on channel 0
    frame(4'b0001);
    chk("frz0_load", 32'(bus_a.freeze), 32'h1);
    chk("frz0_load_b", 32'(bus_b.freeze), 32'h1);
    frame(4'd0);
    frame(4'd0);
    chk("frz0_t2", 32'(bus_a.freeze), 32'h1);
    frame(4'd0);
    chk("frz0_off", 32'(bus_a.freeze), 32'h0);
    chk("frz0_done", 32'(bus_a.freeze_done), 32'h1);
    chk("frz0_done_b", 32'(bus_b.freeze_done), 32'h1);

    // Reset aborts a freeze without a done pulse
    step(7, 7, 1'b0, 4'b0001);
    after_edge();
    chk("frz_rst_pre", 32'(bus_a.freeze), 32'h1);
    rst_g = 1'b1;
    step(5, 5, 1'b0, 4'd0);
    after_edge();
    chk("frz_rst_off", 32'(bus_a.freeze), 32'h0);
    chk("frz_rst_done", 32'(bus_a.freeze_done), 32'h0);
    rst_g = 1'b0;
    repeat (2) begin
      step(5, 5, 1'b0, 4'd0);
      after_edge();
      chk("frz_rst_nodone", 32'(bus_a.freeze_done), 32'h0);
    end
    frame(4'd0);
    chk("frz_rst_idle", 32'(bus_a.freeze), 32'h0);
    chk("frz_rst_idle_done", 32'(bus_a.freeze_done), 32'h0);

    repeat (4) step(5, 5, 1'b0, 4'd0);
    after_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
